// File: rtl/dmem_bus_pkg.sv
// -----------------------------------------------------------------------------
// dmem_bus_pkg
// Shared types and constants for the data-memory bus bridge.
// Optional build macro used by the bridge: DMEM_BRIDGE_MISALIGN_CHECK_EN.
// -----------------------------------------------------------------------------
package dmem_bus_pkg;

    // Bridge FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    // Default REQ+WAIT cycle budget before an access is aborted
    localparam int TIMEOUT_DEFAULT = 255;

    // Read data returned to the core when an access is aborted
    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

    // True when a word access address is not 4-byte aligned
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_bus_timer.sv
// -----------------------------------------------------------------------------
// dmem_bus_timer
// Saturating cycle counter for the bridge access budget. clr has priority
// over en; the count stops at LIMIT-1, where expired is asserted.
// -----------------------------------------------------------------------------
module dmem_bus_timer
    import dmem_bus_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count_r;

    // Count REQ/WAIT cycles, restart on clear, hold once the budget is used up
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (en && (count_r != LAST)) begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    // Budget exhausted flag
    always_comb begin
        expired = (count_r == LAST);
    end

endmodule

// File: rtl/dmem_bus_bridge.sv
// -----------------------------------------------------------------------------
// dmem_bus_bridge
// Converts the MEM-stage single-cycle data port into a valid/ready request
// plus response-valid transaction toward a multi-cycle data memory, stalling
// the pipeline until the access completes.
// Optional build macro: DMEM_BRIDGE_MISALIGN_CHECK_EN -- when defined, a
// request with cpu_addr[1:0] != 0 is rejected in IDLE without any bus
// transaction (IDLE -> DONE, bus_err set, read data 0).
// -----------------------------------------------------------------------------
module dmem_bus_bridge
    import dmem_bus_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    input  logic              cpu_re,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [ADDR_W-1:0] bus_req_addr,
    output logic [DATA_W-1:0] bus_req_wdata,
    output logic              bus_req_we,
    input  logic              bus_resp_valid,
    input  logic [DATA_W-1:0] bus_resp_rdata,
    output logic              bus_err,
    input  logic              err_clr
);

    state_e            state_r;
    state_e            state_s;

    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              we_r;
    logic [DATA_W-1:0] rdata_r;
    logic              err_r;
    logic              valid_r;

    logic              cpu_req_s;
    logic              misalign_s;
    logic              accept_s;
    logic              reject_s;
    logic              complete_s;
    logic              resp_take_s;
    logic              timeout_s;
    logic              err_set_s;
    logic              stall_s;
    logic              tmr_clr_s;
    logic              tmr_en_s;
    logic              tmr_expired_s;

    dmem_bus_timer #(
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr_s),
        .en      (tmr_en_s),
        .expired (tmr_expired_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Control decode: request acceptance, completion, timeout and stall
    always_comb begin
        cpu_req_s = cpu_re | cpu_we;
`ifdef DMEM_BRIDGE_MISALIGN_CHECK_EN
        misalign_s = is_misaligned(cpu_addr[1:0]);
`else
        misalign_s = 1'b0;
`endif
        accept_s    = (state_r == IDLE) && cpu_req_s && !misalign_s;
        reject_s    = (state_r == IDLE) && cpu_req_s && misalign_s;
        resp_take_s = (state_r == WAIT) && bus_resp_valid;
        // A write is finished by the handshake, a read only by its response
        complete_s  = ((state_r == REQ) && bus_req_ready && we_r) || resp_take_s;
        tmr_clr_s   = (state_r == IDLE);
        tmr_en_s    = (state_r == REQ) || (state_r == WAIT);
        timeout_s   = tmr_en_s && tmr_expired_s && !complete_s;
        err_set_s   = timeout_s || reject_s;
        // Gated by reset so the freeze drops the instant reset asserts
        stall_s     = rst && (((state_r == IDLE) && cpu_req_s) ||
                              (state_r == REQ) || (state_r == WAIT));
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (reject_s) begin
                    state_s = DONE;
                end else if (accept_s) begin
                    state_s = REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (timeout_s) begin
                    state_s = DONE;
                end else if (bus_req_ready) begin
                    state_s = we_r ? DONE : WAIT;
                end else begin
                    state_s = REQ;
                end
            end
            WAIT: begin
                if (resp_take_s || timeout_s) begin
                    state_s = DONE;
                end else begin
                    state_s = WAIT;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Request latches, read data, sticky error and registered request valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_r  <= '0;
            wdata_r <= '0;
            we_r    <= 1'b0;
            rdata_r <= '0;
            err_r   <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            if ((state_r == IDLE) && cpu_req_s) begin
                addr_r  <= cpu_addr;
                wdata_r <= cpu_wdata;
                we_r    <= cpu_we;
            end
            if (resp_take_s) begin
                rdata_r <= bus_resp_rdata;
            end else if (timeout_s) begin
                rdata_r <= DATA_W'(ERR_RDATA);
            end else if (reject_s) begin
                rdata_r <= '0;
            end
            // A new error outranks a simultaneous clear
            if (err_set_s) begin
                err_r <= 1'b1;
            end else if (err_clr) begin
                err_r <= 1'b0;
            end
            valid_r <= (state_s == REQ);
        end
    end

    // Output mapping
    always_comb begin
        cpu_rdata     = rdata_r;
        cpu_stall     = stall_s;
        bus_req_valid = valid_r;
        bus_req_addr  = addr_r;
        bus_req_wdata = wdata_r;
        bus_req_we    = we_r;
        bus_err       = err_r;
    end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_dmem_bus_bridge
// Directed and randomized accesses against a transaction-level model of the
// bridge; the bench also plays the multi-cycle memory on the bus side.
// -----------------------------------------------------------------------------
module tb_dmem_bus_bridge;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cpu_addr = 32'h0;
    logic [31:0] cpu_wdata = 32'h0;
    logic        cpu_we = 1'b0;
    logic        cpu_re = 1'b0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        bus_req_valid;
    logic        bus_req_ready = 1'b0;
    logic [31:0] bus_req_addr;
    logic [31:0] bus_req_wdata;
    logic        bus_req_we;
    logic        bus_resp_valid = 1'b0;
    logic [31:0] bus_resp_rdata = 32'h0;
    logic        bus_err;
    logic        err_clr = 1'b0;

    int tests = 0;
    int fails = 0;

    logic [31:0] ref_mem [16];
    logic [31:0] dev_mem [16];
    logic [31:0] exp_rdata;
    logic        exp_err;

    always #5 clk = ~clk;

    dmem_bus_bridge #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (T)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_we         (cpu_we),
        .cpu_re         (cpu_re),
        .cpu_rdata      (cpu_rdata),
        .cpu_stall      (cpu_stall),
        .bus_req_valid  (bus_req_valid),
        .bus_req_ready  (bus_req_ready),
        .bus_req_addr   (bus_req_addr),
        .bus_req_wdata  (bus_req_wdata),
        .bus_req_we     (bus_req_we),
        .bus_resp_valid (bus_resp_valid),
        .bus_resp_rdata (bus_resp_rdata),
        .bus_err        (bus_err),
        .err_clr        (err_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One MEM-stage access: the model predicts its cost and result, the loop
    // drives the bus side and measures what the bridge actually did.
    task automatic do_access(input logic we, input logic re, input logic [31:0] addr,
                             input logic [31:0] wdata, input int rdy_dly,
                             input int resp_dly, input logic clr);
        int   req_exp;
        int   stall_exp;
        logic tmo;
        logic mis;
        int   req_n;
        int   stall_n;
        int   wait_n;
        logic accepted;
        logic done;
        logic exp_we;
        mis    = 1'b0;
        tmo    = 1'b0;
        exp_we = we;
`ifdef DMEM_BRIDGE_MISALIGN_CHECK_EN
        mis = (addr[1:0] != 2'b00);
`endif
        if (mis) begin
            req_exp   = 0;
            stall_exp = 1;
            exp_rdata = 32'h0;
        end else if (we) begin
            if (rdy_dly + 1 > T) begin
                tmo = 1'b1; req_exp = T; stall_exp = T + 1;
            end else begin
                req_exp = rdy_dly + 1; stall_exp = rdy_dly + 2;
                ref_mem[addr[5:2]] = wdata;
            end
        end else begin
            if (rdy_dly + resp_dly + 2 > T) begin
                tmo = 1'b1; stall_exp = T + 1;
                req_exp = (rdy_dly + 1 < T) ? rdy_dly + 1 : T;
            end else begin
                req_exp   = rdy_dly + 1;
                stall_exp = rdy_dly + resp_dly + 3;
                exp_rdata = ref_mem[addr[5:2]];
            end
        end
        if (tmo) exp_rdata = 32'hDEAD_BEEF;
        if (tmo || mis) exp_err = 1'b1;
        else if (clr) exp_err = 1'b0;

        cyc();
        cpu_we = we; cpu_re = re; cpu_addr = addr; cpu_wdata = wdata; err_clr = clr;
        #1;
        check("stall_in_idle", 32'(cpu_stall), 32'd1);
        req_n = 0; stall_n = 1; wait_n = 0; accepted = 1'b0; done = 1'b0;
        for (int g = 0; g < 40 && !done; g++) begin
            @(posedge clk);
            #1;
            bus_req_ready  = 1'b0;
            bus_resp_valid = 1'b0;
            #1;
            if (!cpu_stall) begin
                done = 1'b1;
            end else begin
                stall_n++;
                if (bus_req_valid) begin
                    check("req_addr_stable", bus_req_addr, addr);
                    check("req_wdata_stable", bus_req_wdata, wdata);
                    check("req_we_stable", 32'(bus_req_we), 32'(exp_we));
                    // stray responses outside WAIT must be ignored
                    bus_resp_valid = ($urandom_range(0, 3) == 0);
                    bus_resp_rdata = $urandom;
                    if (req_n == rdy_dly) begin
                        bus_req_ready = 1'b1;
                        accepted = 1'b1;
                        if (we) dev_mem[bus_req_addr[5:2]] = bus_req_wdata;
                    end
                    req_n++;
                end else if (accepted && !we) begin
                    if (wait_n == resp_dly) begin
                        bus_resp_valid = 1'b1;
                        bus_resp_rdata = dev_mem[bus_req_addr[5:2]];
                    end else begin
                        bus_resp_rdata = $urandom;
                    end
                    wait_n++;
                end
            end
        end
        check("done_reached", 32'(done), 32'd1);
        check("stall_cycles", stall_n, stall_exp);
        check("req_cycles", req_n, req_exp);
        check("cpu_rdata", cpu_rdata, exp_rdata);
        check("bus_err", 32'(bus_err), 32'(exp_err));
        check("valid_in_done", 32'(bus_req_valid), 32'd0);
        cpu_we = 1'b0; cpu_re = 1'b0; err_clr = 1'b0;
        bus_resp_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0000_0101;
            dev_mem[i] = ref_mem[i];
        end
        ref_mem[0] = 32'h1234_5678;
        dev_mem[0] = 32'h1234_5678;
        exp_rdata = 32'h0;
        exp_err   = 1'b0;

        // reset state, with a request pending on the CPU side
        cpu_re = 1'b1;
        #12;
        check("rst_stall", 32'(cpu_stall), 32'd0);
        check("rst_valid", 32'(bus_req_valid), 32'd0);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_err", 32'(bus_err), 32'd0);
        check("rst_addr", bus_req_addr, 32'h0);
        cpu_re = 1'b0;
        rst = 1'b1;

        // minimum-latency read
        do_access(1'b0, 1'b1, 32'h0000_0100, 32'h0, 0, 0, 1'b0);
        // write held off for 5 cycles, then a back-to-back read of it
        do_access(1'b1, 1'b0, 32'h0000_0200, 32'hA5A5_A5A5, 5, 0, 1'b0);
        do_access(1'b0, 1'b1, 32'h0000_0300, 32'h0, 1, 2, 1'b0);
        // timeout on a read that never gets a response
        do_access(1'b0, 1'b1, 32'h0000_0104, 32'h0, 0, 100, 1'b0);
        cyc();
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        check("err_clr", 32'(bus_err), 32'd0);
        exp_err = 1'b0;
        // timeout in REQ while err_clr is held: the set wins
        do_access(1'b1, 1'b0, 32'h0000_0108, 32'h0BAD_0BAD, 20, 0, 1'b1);
        // clear with no new error
        do_access(1'b0, 1'b1, 32'h0000_0108, 32'h0, 0, 0, 1'b1);
        // re and we together behave as a write
        do_access(1'b1, 1'b1, 32'h0000_010C, 32'hCAFE_F00D, 0, 0, 1'b0);
        do_access(1'b0, 1'b1, 32'h0000_010C, 32'h0, 2, 0, 1'b0);
        // misaligned address (rejected only when the check is built in)
        do_access(1'b0, 1'b1, 32'h0000_0102, 32'h0, 0, 0, 1'b0);

        // spurious response while idle
        cyc();
        bus_resp_valid = 1'b1;
        bus_resp_rdata = 32'hFFFF_0000;
        #1;
        check("spur_stall", 32'(cpu_stall), 32'd0);
        cyc();
        bus_resp_valid = 1'b0;
        check("spur_rdata", cpu_rdata, exp_rdata);
        check("spur_valid", 32'(bus_req_valid), 32'd0);

        // reset in the middle of WAIT
        cpu_re = 1'b1; cpu_addr = 32'h0000_0110;
        cyc();
        bus_req_ready = 1'b1;
        cyc();
        bus_req_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("rstw_valid", 32'(bus_req_valid), 32'd0);
        check("rstw_stall", 32'(cpu_stall), 32'd0);
        check("rstw_err", 32'(bus_err), 32'd0);
        cyc();
        bus_resp_valid = 1'b1;
        bus_resp_rdata = 32'h5555_AAAA;
        cyc();
        bus_resp_valid = 1'b0;
        cpu_re = 1'b0;
        rst = 1'b1;
        cyc();
        check("rstw_rdata", cpu_rdata, 32'h0);
        check("rstw_idle", 32'(cpu_stall), 32'd0);
        exp_rdata = 32'h0;
        exp_err   = 1'b0;
        do_access(1'b0, 1'b1, 32'h0000_0114, 32'h0, 0, 0, 1'b0);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            int          kind;
            int          rd;
            int          rs;
            logic [31:0] a;
            kind = $urandom_range(0, 2);
            a    = ($urandom & 32'hFFFF_FFC0) | (32'($urandom_range(0, 15)) << 2);
            rd   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 9) : $urandom_range(0, 2);
            rs   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 8) : $urandom_range(0, 2);
            do_access(kind != 0, kind != 1, a, $urandom, rd, rs,
                      ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
